// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/cacheline types and pmem responder state
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lc3b_pmem_state;

    localparam int LC3B_LINE_OFFSET_W = 4;

endpackage

// File: rtl/pmem_line_array.sv
// rtl/pmem_line_array.sv - unreset line storage, synchronous write and registered read
module pmem_line_array
    import lc3b_types::*;
#(
    parameter int IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     windex,
    input  lc3b_cacheline        wdata,
    input  logic                 re,
    input  logic [IDX_W-1:0]     rindex,
    output lc3b_cacheline        rdata
);

    lc3b_cacheline mem [2**IDX_W];
    lc3b_cacheline rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[windex] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[rindex];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - cacheline memory responder with programmable latency,
// one-cycle completion pulse and completed-transaction counters
module pmem_responder
    import lc3b_types::*;
#(
    parameter int IDX_W   = 5,
    parameter int LATENCY = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pmem_read,
    input  logic           pmem_write,
    input  lc3b_word       pmem_address,
    input  lc3b_cacheline  pmem_wdata,
    output logic           pmem_resp,
    output lc3b_cacheline  pmem_rdata,
    output logic           pmem_err,
    output logic [15:0]    rd_count,
    output logic [15:0]    wr_count
);

    localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

    lc3b_pmem_state   state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             op_wr_q, op_wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    lc3b_cacheline    wdata_q, wdata_d;
    logic             err_q, err_d;
    logic [15:0]      rd_cnt_q, rd_cnt_d;
    logic [15:0]      wr_cnt_q, wr_cnt_d;
    logic             rvalid_q, rvalid_d;

    logic             commit;
    logic             commit_wr;
    logic [IDX_W-1:0] commit_idx;
    lc3b_cacheline    commit_wdata;
    logic             req_held;
    lc3b_cacheline    arr_rdata;
    logic [IDX_W-1:0] addr_idx;

    logic unused_addr;
    assign unused_addr = ^{pmem_address[LC3B_LINE_OFFSET_W-1:0],
                           pmem_address[15:IDX_W+LC3B_LINE_OFFSET_W]};

    assign addr_idx = pmem_address[IDX_W+LC3B_LINE_OFFSET_W-1:LC3B_LINE_OFFSET_W];
    assign req_held = op_wr_q ? pmem_write : pmem_read;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_wr_d      = op_wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        rvalid_d     = rvalid_q;
        commit       = 1'b0;
        commit_wr    = op_wr_q;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (pmem_read ^ pmem_write) begin
                    op_wr_d = pmem_write;
                    idx_d   = addr_idx;
                    wdata_d = pmem_wdata;
                    if (LATENCY == 1) begin
                        // Single-cycle latency commits straight from the live inputs.
                        state_d      = RESP;
                        commit       = 1'b1;
                        commit_wr    = pmem_write;
                        commit_idx   = addr_idx;
                        commit_wdata = pmem_wdata;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LAT_LOAD;
                    end
                end else if (pmem_read && pmem_write) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                if (!req_held) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            if (commit_wr) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 16'd1;
                rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    pmem_line_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (commit && commit_wr),
        .windex (commit_idx),
        .wdata  (commit_wdata),
        .re     (commit && !commit_wr),
        .rindex (commit_idx),
        .rdata  (arr_rdata)
    );

    // The array itself has no reset, so the visible read line is masked until the first read.
    assign pmem_rdata = rvalid_q ? arr_rdata : '0;
    assign pmem_resp  = (state_q == RESP);
    assign pmem_err   = err_q;
    assign rd_count   = rd_cnt_q;
    assign wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - directed bench for pmem_responder at LATENCY 4 and 1
module tb_pmem_responder;

    logic         clk;
    logic         rst   [2];
    logic         rd    [2];
    logic         wr    [2];
    logic [15:0]  addr  [2];
    logic [127:0] wd    [2];
    logic         resp  [2];
    logic [127:0] rdata [2];
    logic         err   [2];
    logic [15:0]  rdc   [2];
    logic [15:0]  wrc   [2];

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [127:0] D3 = 128'h55555555_AAAAAAAA_12345678_9ABCDEF0;
    localparam logic [127:0] D4 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
    localparam logic [127:0] D5 = 128'h0F0F0F0F_F0F0F0F0_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] D6 = 128'hCAFEF00D_BAADC0DE_13579BDF_2468ACE0;

    pmem_responder #(.IDX_W(5), .LATENCY(4)) u_dut4 (
        .clk(clk), .reset(rst[0]), .pmem_read(rd[0]), .pmem_write(wr[0]),
        .pmem_address(addr[0]), .pmem_wdata(wd[0]), .pmem_resp(resp[0]),
        .pmem_rdata(rdata[0]), .pmem_err(err[0]), .rd_count(rdc[0]), .wr_count(wrc[0])
    );

    pmem_responder #(.IDX_W(5), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .pmem_read(rd[1]), .pmem_write(wr[1]),
        .pmem_address(addr[1]), .pmem_wdata(wd[1]), .pmem_resp(resp[1]),
        .pmem_rdata(rdata[1]), .pmem_err(err[1]), .rd_count(rdc[1]), .wr_count(wrc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; the request is visible from that cycle (cycle 0).
    task automatic txn(input int d, input bit w, input logic [15:0] a,
                       input logic [127:0] data, output int lat);
        addr[d] = a;
        wd[d]   = data;
        if (w) wr[d] = 1'b1;
        else   rd[d] = 1'b1;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (resp[d]) begin
                lat = c;
                break;
            end
        end
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    task automatic count_resp(input int d, input int cycles, output int hits);
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (resp[d]) hits++;
        end
    endtask

    initial begin
        int lat;
        int hits;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wd[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp",  128'(resp[0]), 128'd0);
        chk("reset_rdata", rdata[0], 128'd0);
        chk("reset_err",   128'(err[0]), 128'd0);
        chk("reset_rdc",   128'(rdc[0]), 128'd0);
        chk("reset_wrc",   128'(wrc[0]), 128'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;

        // LATENCY=4 write then read of the same line through a different offset
        txn(0, 1'b1, 16'h0040, D1, lat);
        chk("l4_wr_lat", 128'(lat), 128'd4);
        txn(0, 1'b0, 16'h004A, '0, lat);
        chk("l4_rd_lat",   128'(lat), 128'd4);
        chk("l4_rd_data",  rdata[0], D1);
        chk("l4_wrc",      128'(wrc[0]), 128'd1);
        chk("l4_rdc",      128'(rdc[0]), 128'd1);

        // Aliasing: 0x0210 maps to the same line as 0x0010
        txn(0, 1'b1, 16'h0010, D2, lat);
        txn(0, 1'b0, 16'h0210, '0, lat);
        chk("alias_data", rdata[0], D2);
        chk("alias_rdc",  128'(rdc[0]), 128'd2);

        // Abort: read dropped in cycle 2
        addr[0] = 16'h0080;
        rd[0]   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd[0] = 1'b0;
        count_resp(0, 8, hits);
        chk("abort_noresp", 128'(hits), 128'd0);
        chk("abort_rdata",  rdata[0], D2);
        chk("abort_rdc",    128'(rdc[0]), 128'd2);
        @(posedge clk); #1;
        txn(0, 1'b0, 16'h0040, '0, lat);
        chk("post_abort_lat",  128'(lat), 128'd4);
        chk("post_abort_data", rdata[0], D1);
        chk("post_abort_rdc",  128'(rdc[0]), 128'd3);

        // Illegal: read and write together in IDLE
        addr[0] = 16'h0050;
        rd[0]   = 1'b1;
        wr[0]   = 1'b1;
        count_resp(0, 6, hits);
        chk("illegal_noresp", 128'(hits), 128'd0);
        chk("illegal_err",    128'(err[0]), 128'd1);
        @(posedge clk); #1;
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        txn(0, 1'b1, 16'h0050, D3, lat);
        chk("after_illegal_lat", 128'(lat), 128'd4);
        chk("err_sticky",        128'(err[0]), 128'd1);
        chk("after_illegal_wrc", 128'(wrc[0]), 128'd3);

        // Reset during a write to 0x0300 whose line already holds D5
        txn(0, 1'b1, 16'h0300, D5, lat);
        addr[0] = 16'h0300;
        wd[0]   = D4;
        wr[0]   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst[0] = 1'b1;
        #1;
        chk("midreset_resp",  128'(resp[0]), 128'd0);
        chk("midreset_rdata", rdata[0], 128'd0);
        chk("midreset_err",   128'(err[0]), 128'd0);
        chk("midreset_rdc",   128'(rdc[0]), 128'd0);
        chk("midreset_wrc",   128'(wrc[0]), 128'd0);
        wr[0] = 1'b0;
        #3;
        rst[0] = 1'b0;
        @(posedge clk); #1;
        txn(0, 1'b0, 16'h0300, '0, lat);
        chk("nocommit_data", rdata[0], D5);
        chk("nocommit_rdc",  128'(rdc[0]), 128'd1);
        txn(0, 1'b0, 16'h0040, '0, lat);
        chk("keep_line_data", rdata[0], D1);
        txn(0, 1'b0, 16'h0050, '0, lat);
        chk("keep_line_d3", rdata[0], D3);

        // LATENCY=1 back-to-back write then read with no idle gap
        txn(1, 1'b1, 16'h0200, D6, lat);
        chk("l1_wr_lat", 128'(lat), 128'd1);
        txn(1, 1'b0, 16'h0200, '0, lat);
        chk("l1_rd_lat",  128'(lat), 128'd1);
        chk("l1_rd_data", rdata[1], D6);
        chk("l1_rdc",     128'(rdc[1]), 128'd1);
        chk("l1_wrc",     128'(wrc[1]), 128'd1);
        @(negedge clk);
        chk("l1_resp_single", 128'(resp[1]), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
